// File: rtl/mac_pkg.sv
// Shared defaults, FSM encoding and width helper for the MAC sharing arbiter.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned LEN_DEF    = 4;
  localparam int unsigned OUT_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Register width able to hold values 0..v-1, never narrower than 1 bit.
  function automatic int unsigned idx_w(input int unsigned v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);

  // Walk from the pointer upward and keep the first request found.
  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N;
      if ((grant == '0) && req[idx]) grant[idx] = 1'b1;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mac_share_arbiter.sv
// Time-shares one MAC between N_REQ requesters: grant, feed LEN pairs, wait, respond.
module mac_share_arbiter
  import mac_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN     = LEN_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [DATA_W*N_REQ-1:0]   req_a,
  input  logic [DATA_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [OUT_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      mac_in_valid,
  output logic [DATA_W-1:0]         mac_in1,
  output logic [DATA_W-1:0]         mac_in2,
  input  logic                      mac_out_valid,
  input  logic [OUT_W-1:0]          mac_out,
  output logic                      busy,
  output logic                      spurious
);

  localparam int unsigned PTR_W = idx_w(N_REQ);
  localparam int unsigned CNT_W = idx_w(LEN);
  localparam int unsigned TMR_W = idx_w(TIMEOUT);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                in_valid_q, in_valid_d;
  logic [DATA_W-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic                err_q, err_d;
  logic                spur_q, spur_d;

  logic [N_REQ-1:0]    grant;
  logic                any_req;
  logic [PTR_W-1:0]    win_idx;
  logic                xfer;
  logic [DATA_W-1:0]   a_sel, b_sel;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any_req)
  );

  // Encode the one-hot grant into the owner index.
  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) win_idx = PTR_W'(k);
    end
  end

  assign a_sel = req_a[32'(owner_q)*DATA_W +: DATA_W];
  assign b_sel = req_b[32'(owner_q)*DATA_W +: DATA_W];
  assign xfer  = (state_q == ST_FEED) && req_valid[owner_q];

  // Next-state and datapath update for the burst FSM.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    in_valid_d = 1'b0;
    in1_d      = in1_q;
    in2_d      = in2_q;
    data_d     = data_q;
    err_d      = err_q;
    spur_d     = spur_q | (mac_out_valid && (state_q != ST_WAIT));
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_FEED;
          owner_d = win_idx;
          ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          cnt_d   = '0;
        end
      end
      ST_FEED: begin
        if (xfer) begin
          in_valid_d = 1'b1;
          in1_d      = a_sel;
          in2_d      = b_sel;
          if (cnt_q == CNT_W'(LEN - 1)) begin
            cnt_d   = '0;
            timer_d = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A result arriving on the last timer cycle still counts as success.
        if (mac_out_valid) begin
          data_d  = mac_out;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = ST_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      in_valid_q <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      in_valid_q <= in_valid_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      data_q     <= data_d;
      err_q      <= err_d;
      spur_q     <= spur_d;
    end
  end

  // Handshake strobes decoded from registered state so they never depend on inputs.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ST_FEED) req_ready[owner_q] = 1'b1;
    if (state_q == ST_RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign mac_in_valid = in_valid_q;
  assign mac_in1      = in1_q;
  assign mac_in2      = in2_q;
  assign busy         = (state_q != ST_IDLE);
  assign spurious     = spur_q;

endmodule
